// File: rtl/ac_motor_pwm_gate.sv
// ac_motor_pwm_gate
//   Three-phase PWM gate stage. Compares three signed phase references against
//   the shared triangle carrier, applies the CW/CCW phase order, inserts dead
//   time per leg and drives the high/low-side gates of a 3-leg inverter bridge.
//
// Ports
//   CLK          system clock, rising edge
//   RESET        asynchronous active-high reset
//   ENABLE       1 = modulate, 0 = all gates off
//   TRIANGLE     signed carrier
//   CW_OUT       direction flag (clockwise)
//   CCW_OUT      direction flag (counter-clockwise)
//   REF_A/B/C    signed phase references
//   FAULT        external fault, active-high
//   FAULT_CLR    fault clear pulse (latched build only)
//   GATE_H       high-side gates, bit0=A bit1=B bit2=C
//   GATE_L       low-side gates, same order
//   FAULT_ACTIVE 1 while gates are forced off by a fault
//
// Build option
//   FAULT_LATCH_EN : when defined, FAULT sets a sticky flag cleared by
//                    FAULT_CLR (only while FAULT=0) or RESET. When undefined,
//                    FAULT_ACTIVE is a one-cycle registered copy of FAULT.
module ac_motor_pwm_gate #(
  parameter int CARRIER_BITS = 17,
  parameter int DEAD_CYCLES  = 50,
  parameter int CNT_BITS     = 8
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           ENABLE,
  input  logic signed [CARRIER_BITS-1:0] TRIANGLE,
  input  logic                           CW_OUT,
  input  logic                           CCW_OUT,
  input  logic signed [CARRIER_BITS-1:0] REF_A,
  input  logic signed [CARRIER_BITS-1:0] REF_B,
  input  logic signed [CARRIER_BITS-1:0] REF_C,
  input  logic                           FAULT,
  input  logic                           FAULT_CLR,
  output logic [2:0]                     GATE_H,
  output logic [2:0]                     GATE_L,
  output logic                           FAULT_ACTIVE
);

  localparam logic [2:0] ST_OFF  = 3'd0;
  localparam logic [2:0] ST_DT_L = 3'd1;
  localparam logic [2:0] ST_LOW  = 3'd2;
  localparam logic [2:0] ST_DT_H = 3'd3;
  localparam logic [2:0] ST_HIGH = 3'd4;

  localparam logic [CNT_BITS-1:0] DEAD_LOAD = CNT_BITS'(DEAD_CYCLES - 1);

  logic                         dir_valid;
  logic                         dir_ccw;
  logic                         run;
  logic [2:0][CARRIER_BITS-1:0] ref_map;
  logic [2:0]                   cmp_q;
  logic                         fault_active_reg;

  // Exactly one direction flag must be set; anything else stops modulation.
  assign dir_valid = CW_OUT ^ CCW_OUT;
  assign dir_ccw   = CCW_OUT & ~CW_OUT;
  assign run       = ENABLE & dir_valid & ~fault_active_reg;

  // CCW order swaps the B and C references.
  always_comb begin
    ref_map[0] = REF_A;
    ref_map[1] = dir_ccw ? REF_C : REF_B;
    ref_map[2] = dir_ccw ? REF_B : REF_C;
  end

`ifdef FAULT_LATCH_EN
  // Sticky flag; FAULT has priority so a clear during an active fault is ignored.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          fault_active_reg <= 1'b0;
    else if (FAULT)     fault_active_reg <= 1'b1;
    else if (FAULT_CLR) fault_active_reg <= 1'b0;
  end
`else
  logic unused_fault_clr;
  assign unused_fault_clr = FAULT_CLR;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) fault_active_reg <= 1'b0;
    else       fault_active_reg <= FAULT;
  end
`endif

  assign FAULT_ACTIVE = fault_active_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_leg
      logic [2:0]          state_reg;
      logic [2:0]          state_next;
      logic [CNT_BITS-1:0] cnt_reg;
      logic [CNT_BITS-1:0] cnt_next;

      // Registered compare; equality counts as "carrier not below reference".
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) cmp_q[gi] <= 1'b0;
        else       cmp_q[gi] <= ($signed(ref_map[gi]) > $signed(TRIANGLE));
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (!run) begin
          state_next = ST_OFF;
        end else begin
          case (state_reg)
            ST_OFF: begin
              state_next = cmp_q[gi] ? ST_DT_H : ST_DT_L;
              cnt_next   = DEAD_LOAD;
            end
            ST_DT_L: begin
              if (cmp_q[gi]) begin
                state_next = ST_DT_H;
                cnt_next   = DEAD_LOAD;
              end else if (cnt_reg == '0) begin
                state_next = ST_LOW;
              end else begin
                cnt_next = cnt_reg - 1'b1;
              end
            end
            ST_LOW: begin
              if (cmp_q[gi]) begin
                state_next = ST_DT_H;
                cnt_next   = DEAD_LOAD;
              end
            end
            ST_DT_H: begin
              if (!cmp_q[gi]) begin
                state_next = ST_DT_L;
                cnt_next   = DEAD_LOAD;
              end else if (cnt_reg == '0) begin
                state_next = ST_HIGH;
              end else begin
                cnt_next = cnt_reg - 1'b1;
              end
            end
            ST_HIGH: begin
              if (!cmp_q[gi]) begin
                state_next = ST_DT_L;
                cnt_next   = DEAD_LOAD;
              end
            end
            default: state_next = ST_OFF;
          endcase
        end
      end

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          state_reg <= ST_OFF;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // Gates decode straight from the state register: one state per gate,
      // so both can never be high together.
      assign GATE_H[gi] = (state_reg == ST_HIGH);
      assign GATE_L[gi] = (state_reg == ST_LOW);
    end
  endgenerate

endmodule

// File: tb/tb_ac_motor_pwm_gate.sv
module tb_ac_motor_pwm_gate;
  localparam int CB = 17;
  localparam int D  = 4;

  logic                 CLK = 1'b0;
  logic                 RESET, ENABLE, CW_OUT, CCW_OUT, FAULT, FAULT_CLR;
  logic signed [CB-1:0] TRIANGLE, REF_A, REF_B, REF_C;
  logic [2:0]           GATE_H, GATE_L;
  logic                 FAULT_ACTIVE;

  ac_motor_pwm_gate #(.CARRIER_BITS(CB), .DEAD_CYCLES(D), .CNT_BITS(8)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .TRIANGLE(TRIANGLE),
    .CW_OUT(CW_OUT), .CCW_OUT(CCW_OUT), .REF_A(REF_A), .REF_B(REF_B),
    .REF_C(REF_C), .FAULT(FAULT), .FAULT_CLR(FAULT_CLR), .GATE_H(GATE_H),
    .GATE_L(GATE_L), .FAULT_ACTIVE(FAULT_ACTIVE)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         edge_no;
    logic [2:0] h;
    logic [2:0] l;
    logic       fa;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   drain_req = 1'b0;

  // Expected outputs as seen after edge (current edge + k).
  task automatic expect_out(input int k, input logic [2:0] h, input logic [2:0] l,
                            input logic fa, input string nm);
    exp_t e;
    e.edge_no = edge_cnt + k;
    e.h = h; e.l = l; e.fa = fa; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: samples on the falling edge, checks the overlap invariant each
  // cycle and pops every scoreboard entry due at the current edge.
  always @(negedge CLK) begin
    n_tests++;
    if ((GATE_H & GATE_L) != 3'b000) begin
      n_fail++;
      $display("[TB] FAIL overlap edge=%0d got H=%b L=%b required no common bit",
               edge_cnt, GATE_H, GATE_L);
    end
    while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if (mon_e.edge_no != edge_cnt || GATE_H !== mon_e.h || GATE_L !== mon_e.l ||
          FAULT_ACTIVE !== mon_e.fa) begin
        n_fail++;
        $display("[TB] FAIL %s edge=%0d(due %0d) got H=%b L=%b FA=%b required H=%b L=%b FA=%b",
                 mon_e.name, edge_cnt, mon_e.edge_no, GATE_H, GATE_L, FAULT_ACTIVE,
                 mon_e.h, mon_e.l, mon_e.fa);
      end else begin
        $display("[TB] ok %s edge=%0d H=%b L=%b FA=%b", mon_e.name, edge_cnt,
                 GATE_H, GATE_L, FAULT_ACTIVE);
      end
    end
    if (drain_req && exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain got %0d pending entries required 0", exp_q.size());
      exp_q.delete();
    end
  end

  // Startup sequence from OFF with cmp_q initially 0 (CW, TRIANGLE=0):
  // A,B go OFF->DT_L->DT_H->HIGH, C goes OFF->DT_L->LOW.
  task automatic expect_cold_start(input string nm);
    for (int k = 1; k <= 4; k++) expect_out(k, 3'b000, 3'b000, 1'b0, nm);
    expect_out(5, 3'b000, 3'b100, 1'b0, nm);
    expect_out(6, 3'b011, 3'b100, 1'b0, nm);
  endtask

  // Restart from OFF with cmp_q already settled: every leg goes straight to
  // its dead-time state and conducts after D cycles.
  task automatic expect_warm_start(input int first_k, input string nm);
    for (int k = 1; k < first_k + 4; k++) expect_out(k, 3'b000, 3'b000, 1'b0, nm);
    expect_out(first_k + 4, 3'b011, 3'b100, 1'b0, nm);
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; CW_OUT = 1'b1; CCW_OUT = 1'b0;
    FAULT = 1'b0; FAULT_CLR = 1'b0;
    TRIANGLE = 0; REF_A = 1000; REF_B = 500; REF_C = -500;

    // Reset state
    tick(1);
    expect_out(1, 3'b000, 3'b000, 1'b0, "reset_state");
    tick(1);

    // Reset release with cmp_q=0
    RESET = 1'b0;
    expect_cold_start("startup");
    tick(7);

    // Carrier steps above all references: conducting high sides fall, lows rise after D
    TRIANGLE = 2000;
    expect_out(1, 3'b011, 3'b100, 1'b0, "step_cmp_edge");
    for (int k = 2; k <= 5; k++) expect_out(k, 3'b000, 3'b100, 1'b0, "step_dead");
    expect_out(6, 3'b000, 3'b111, 1'b0, "step_low");
    tick(7);

    // Chatter while A,B sit in dead time: they must never conduct
    TRIANGLE = 0;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      TRIANGLE = (i % 2 == 0) ? 17'sd2000 : 17'sd0;
      expect_out(1, 3'b000, 3'b100, 1'b0, "chatter");
      expect_out(2, 3'b000, 3'b100, 1'b0, "chatter");
      tick(2);
    end

    // ENABLE=0 while running
    ENABLE = 1'b0;
    expect_out(1, 3'b000, 3'b000, 1'b0, "enable_off");
    expect_out(2, 3'b000, 3'b000, 1'b0, "enable_off_hold");
    tick(3);
    ENABLE = 1'b1;
    expect_warm_start(1, "reenable");
    tick(6);

    // CW -> CCW: B and C swap references, full dead time each
    CW_OUT = 1'b0; CCW_OUT = 1'b1;
    expect_out(1, 3'b011, 3'b100, 1'b0, "dir_cmp_edge");
    for (int k = 2; k <= 5; k++) expect_out(k, 3'b001, 3'b000, 1'b0, "dir_dead");
    expect_out(6, 3'b101, 3'b010, 1'b0, "dir_swapped");
    tick(7);

    // Both direction flags set: all off next edge
    CW_OUT = 1'b1;
    expect_out(1, 3'b000, 3'b000, 1'b0, "dir_invalid");
    tick(2);
    ENABLE = 1'b0; CCW_OUT = 1'b0;
    expect_out(1, 3'b000, 3'b000, 1'b0, "dir_invalid_hold");
    expect_out(2, 3'b000, 3'b000, 1'b0, "dir_invalid_hold");
    tick(3);
    ENABLE = 1'b1;
    expect_warm_start(1, "dir_restart");
    tick(6);

    // One-cycle fault pulse
`ifdef FAULT_LATCH_EN
    FAULT = 1'b1; FAULT_CLR = 1'b1;   // clear ignored while FAULT=1
    expect_out(1, 3'b011, 3'b100, 1'b1, "fault_set");
    tick(1);
    FAULT = 1'b0; FAULT_CLR = 1'b0;
    for (int k = 1; k <= 3; k++) expect_out(k, 3'b000, 3'b000, 1'b1, "fault_latched");
    tick(3);
    FAULT_CLR = 1'b1;
    expect_out(1, 3'b000, 3'b000, 1'b0, "fault_clr");
    tick(1);
    FAULT_CLR = 1'b0;
    expect_warm_start(1, "fault_resume");
    tick(6);
`else
    FAULT = 1'b1;
    expect_out(1, 3'b011, 3'b100, 1'b1, "fault_pulse");
    tick(1);
    FAULT = 1'b0;
    expect_warm_start(2, "fault_resume");
    tick(7);
`endif

    // Asynchronous reset mid-operation, asserted just after a rising edge
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    expect_out(0, 3'b000, 3'b000, 1'b0, "async_reset");
    tick(1);
    expect_out(1, 3'b000, 3'b000, 1'b0, "reset_hold_mid");
    tick(1);
    RESET = 1'b0;
    expect_cold_start("restart");
    tick(7);

    // Let the scoreboard drain, bounded
    tick(10);
    drain_req = 1'b1;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
